tft_pin_in: RTL and testbench
=============================

// Module: tft_pin_in
// PURPOSE
//  Avalon-MM slave input PIO: the CPU-read counterpart of the TFT control-pin output ports.
//  Samples external TFT-board status pins (touch PENIRQ, SD card-detect, busy), then
//  synchronises and debounces them, captures edges, and raises a maskable IRQ to the Nios II.
//  Sits on the system interconnect beside the pin output PIOs; 32-bit data path, 2-bit word address.
// PARAMETERS
//  WIDTH            4      number of input pins, 1..32
//  DEBOUNCE_CYCLES  50000  consecutive stable clk cycles before a level is accepted; 0 = bypass
//  EDGE_MODE        1      edge that sets capture bits: 0 rising, 1 falling, 2 any
//  INIT_LEVEL       all 1  reset value of sync/stable state (pins have pull-ups)
// PORTS
//  clk         in   1      system clock
//  reset       in   1      synchronous, active-high reset
//  address     in   2      word address
//  chipselect  in   1      slave select
//  write_n     in   1      active-low write strobe
//  writedata   in   32     write data
//  readdata    out  32     read data, zero read latency (combinational from registers)
//  in_port     in   WIDTH  asynchronous external pins
//  irq         out  1      level interrupt to CPU
// BEHAVIOUR
//  Register map, read/write:
//   0 DATA  RO   debounced pin levels in [WIDTH-1:0]; writes are ignored.
//   1 MASK  RW   per-bit IRQ enable.
//   2 EDGE  R/W1C  captured edges; writing 1 to a bit clears it, writing 0 leaves it.
//   3 --    reads 0; writes are ignored.
//   Bits [31:WIDTH] of readdata always read 0. The read mux ignores chipselect.
//  Write strobe = chipselect & ~write_n, committed on the clk edge.
//  Reset (reset=1 at a clk edge): sync stages and stable <= INIT_LEVEL; counters, MASK
//   and EDGE <= 0; irq=0 the following cycle. Reset mid-debounce discards the partial count.
//  Per bit: 2-flop synchroniser -> s. Counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
//   If s==stable: cnt<=0.
//   Else if cnt==DEBOUNCE_CYCLES-1: stable<=s, cnt<=0.
//   Else cnt<=cnt+1. Any glitch back to stable restarts the count; cnt never wraps.
//   DEBOUNCE_CYCLES=0: stable<=s every cycle, with no counter.
//  Latency: pin step -> DATA change = 2 + DEBOUNCE_CYCLES clk cycles.
//  Edge: on the cycle stable updates, EDGE[i]<=1 if the transition matches EDGE_MODE.
//   Same-cycle new edge and W1C on the same bit: set wins (bit stays 1).
//   EDGE bits set regardless of MASK.
//  irq = |(EDGE & MASK), combinational from registers.
//   irq asserts the cycle after EDGE sets; it also asserts immediately if MASK is written
//   over an already-pending EDGE bit. It deasserts the cycle after the last enabled bit is cleared.
// STRUCTURE
//  Shared package tft_pio_pkg holds:
//   - register offsets ADDR_DATA=0, ADDR_MASK=1, ADDR_EDGE=2;
//   - EDGE_RISE=0, EDGE_FALL=1, EDGE_ANY=2.
//  Sub-module pin_debounce: one bit, containing the synchroniser, counter and stable flop,
//   with outputs stable and a 1-cycle rise/fall pulse. Instantiated WIDTH times via generate.
//  The top level holds MASK, EDGE, the read mux and irq.
// TESTING  (bench: WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_MODE=1, INIT_LEVEL=4'hF)
//  1. Reset -> DATA=0xF, MASK=0, EDGE=0, irq=0. Write addr0=0x0 -> DATA still 0xF.
//  2. Hold in_port[0]=0 -> DATA=0xE exactly 6 cycles later; EDGE=0x1; irq stays 0 (masked).
//  3. Pulse in_port[1] low for 3 cycles -> DATA, EDGE and cnt are unchanged (glitch rejected).
//  4. With EDGE=0x1, write MASK=0x1 -> irq=1 next cycle.
//     Then write EDGE=0x1 -> EDGE=0, irq=0 next cycle.
//  5. Issue a W1C of bit2 on the same cycle bit2's falling edge is accepted -> EDGE[2]=1, irq=1 if masked.
//  6. Assert reset while in_port[3] is mid-count (cnt=2) -> cnt=0 and DATA[3]=1; the full 6-cycle delay then applies.

Source files
------------

// File: rtl/tft_pio_pkg.sv
// Shared definitions for the TFT pin PIO slaves: register offsets and edge-select codes.
package tft_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  // Picks which accepted transition sets a capture bit for a given edge mode.
  function automatic logic edge_hit(input int mode, input logic rise, input logic fall);
    case (mode)
      EDGE_RISE: return rise;
      EDGE_FALL: return fall;
      default:   return rise | fall;
    endcase
  endfunction

endpackage

// File: rtl/pin_debounce.sv
// One input pin: 2-flop synchroniser, stability counter and accepted level, plus a
// single-cycle rise/fall strobe that is high in the cycle before the level updates.
module pin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        INIT_LEVEL      = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q;
  logic s_q;
  logic stable_q;
  logic accept;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= INIT_LEVEL;
      s_q     <= INIT_LEVEL;
    end else begin
      sync1_q <= pin_i;
      s_q     <= sync1_q;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign accept = (s_q != stable_q);
    end else begin : g_count
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          accept_c;

      // NOTE: every always_comb output gets a default first so no latch is inferred.
      always_comb begin
        cnt_d    = '0;
        accept_c = 1'b0;
        if (s_q != stable_q) begin
          if (cnt_q == LAST) accept_c = 1'b1;
          else               cnt_d    = cnt_q + CW'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
      end

      assign accept = accept_c;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset)       stable_q <= INIT_LEVEL;
    else if (accept) stable_q <= s_q;
  end

  assign stable_o = stable_q;
  assign rise_o   = accept & s_q;
  assign fall_o   = accept & ~s_q;

endmodule

// File: rtl/tft_pin_in.sv
// Avalon-MM input PIO for TFT-board status pins: debounced levels, maskable edge capture
// with write-1-to-clear, and a level IRQ to the CPU.
module tft_pin_in
  import tft_pio_pkg::*;
#(
  parameter int                WIDTH           = 4,
  parameter int unsigned       DEBOUNCE_CYCLES = 50000,
  parameter int                EDGE_MODE       = EDGE_FALL,
  parameter logic [WIDTH-1:0]  INIT_LEVEL      = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] hit;

  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] edge_q, edge_d;
  logic             wr;
  logic             unused_wdata;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
      pin_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .INIT_LEVEL      (INIT_LEVEL[i])
      ) u_pin (
        .clk      (clk),
        .reset    (reset),
        .pin_i    (in_port[i]),
        .stable_o (stable[i]),
        .rise_o   (rise[i]),
        .fall_o   (fall[i])
      );
      assign hit[i] = edge_hit(EDGE_MODE, rise[i], fall[i]);
    end
  endgenerate

  assign wr           = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // A new edge is OR-ed in after the clear so it survives a same-cycle W1C.
  always_comb begin
    mask_d = mask_q;
    edge_d = edge_q;
    if (wr && address == ADDR_MASK) mask_d = writedata[WIDTH-1:0];
    if (wr && address == ADDR_EDGE) edge_d = edge_q & ~writedata[WIDTH-1:0];
    edge_d = edge_d | hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q <= '0;
      edge_q <= '0;
    end else begin
      mask_q <= mask_d;
      edge_q <= edge_d;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: readdata[WIDTH-1:0] = stable;
      ADDR_MASK: readdata[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata[WIDTH-1:0] = edge_q;
      default:   readdata = '0;
    endcase
  end

  assign irq = |(edge_q & mask_q);

endmodule

// File: tb/tb_tft_pin_in.sv
// Bench for tft_pin_in: directed scenarios plus randomized pins/writes against a
// window-based model of debounce acceptance and edge/mask register behaviour.
module tb_tft_pin_in;

  localparam int W = 4;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   address;
  logic         chipselect;
  logic         write_n;
  logic [31:0]  writedata;
  logic [31:0]  readdata;
  logic [W-1:0] in_port;
  logic         irq;

  always #5 clk = ~clk;

  tft_pin_in #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (N),
    .EDGE_MODE       (1),
    .INIT_LEVEL      (4'hF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  int passed = 0;
  int total  = 0;

  // Model: pin value seen at each clock edge; a level is accepted once the last N
  // synchronised samples (two edges old) all differ from the accepted level.
  logic [W-1:0] hist [0:8191];
  int           e;
  logic [W-1:0] m_stable, m_edge, m_mask;

  task automatic model_edge(input logic rst, input logic we, input logic [1:0] a,
                            input logic [31:0] wd, input logic [W-1:0] pins);
    logic [W-1:0] set_b;
    set_b   = '0;
    hist[e] = pins;
    if (rst) begin
      m_stable  = '1;
      m_edge    = '0;
      m_mask    = '0;
      hist[e]   = '1;
      hist[e-1] = '1;
    end else begin
      for (int i = 0; i < W; i++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int j = 0; j < N; j++)
          if (hist[e-2-j][i] == m_stable[i]) all_diff = 1'b0;
        if (all_diff) begin
          if (m_stable[i]) set_b[i] = 1'b1;
          m_stable[i] = ~m_stable[i];
        end
      end
      if (we && a == 2'd2) m_edge = m_edge & ~wd[W-1:0];
      m_edge = m_edge | set_b;
      if (we && a == 2'd1) m_mask = wd[W-1:0];
    end
    e++;
  endtask

  task automatic cycle(input logic rst, input logic we, input logic [1:0] a,
                       input logic [31:0] wd, input logic [W-1:0] pins);
    reset      = rst;
    chipselect = we;
    write_n    = ~we;
    address    = a;
    writedata  = wd;
    in_port    = pins;
    @(posedge clk);
    model_edge(rst, we, a, wd, pins);
    #1;
    reset      = 1'b0;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    #1;
    d = readdata;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    cycle(1, 0, 0, 0, 4'hF);
    cycle(1, 0, 0, 0, 4'hF);
    rd(0, d); total++; if (d !== 32'hF) $display("FAIL reset_data got %h want %h", d, 32'hF); else passed++;
    rd(1, d); total++; if (d !== 32'h0) $display("FAIL reset_mask got %h want %h", d, 32'h0); else passed++;
    rd(2, d); total++; if (d !== 32'h0) $display("FAIL reset_edge got %h want %h", d, 32'h0); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL reset_irq got %b want 0", irq); else passed++;
    cycle(0, 1, 0, 32'h0, 4'hF);
    rd(0, d); total++; if (d !== 32'hF) $display("FAIL data_write_ignored got %h want %h", d, 32'hF); else passed++;
    cycle(0, 1, 3, 32'hFFFF_FFFF, 4'hF);
    rd(3, d); total++; if (d !== 32'h0) $display("FAIL addr3_read got %h want 0", d); else passed++;
    rd(1, d); total++; if (d !== 32'h0) $display("FAIL addr3_write_leak got %h want 0", d); else passed++;
  endtask

  task automatic test_debounce();
    logic [31:0] d;
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 0, 0, 0, 4'hE);
      rd(0, d);
      total++;
      if (d !== ((k < 6) ? 32'hF : 32'hE)) $display("FAIL debounce_latency cyc%0d got %h want %h", k, d, (k < 6) ? 32'hF : 32'hE);
      else passed++;
    end
    rd(2, d); total++; if (d !== 32'h1) $display("FAIL fall_edge_capture got %h want 1", d); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL masked_irq got %b want 0", irq); else passed++;
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    logic [W-1:0] pat [15];
    pat = '{4'hC, 4'hC, 4'hC, 4'hE, 4'hC, 4'hC, 4'hC,
            4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE, 4'hE};
    for (int k = 0; k < 15; k++) begin
      cycle(0, 0, 0, 0, pat[k]);
      rd(0, d); total++; if (d !== 32'hE) $display("FAIL glitch_data cyc%0d got %h want %h", k, d, 32'hE); else passed++;
    end
    rd(2, d); total++; if (d !== 32'h1) $display("FAIL glitch_edge got %h want 1", d); else passed++;
  endtask

  task automatic test_mask_irq();
    logic [31:0] d;
    cycle(0, 1, 1, 32'h1, 4'hE);
    total++; if (irq !== 1'b1) $display("FAIL mask_pending_irq got %b want 1", irq); else passed++;
    rd(1, d); total++; if (d !== 32'h1) $display("FAIL mask_readback got %h want 1", d); else passed++;
    cycle(0, 1, 2, 32'h1, 4'hE);
    total++; if (irq !== 1'b0) $display("FAIL w1c_irq got %b want 0", irq); else passed++;
    rd(2, d); total++; if (d !== 32'h0) $display("FAIL w1c_edge got %h want 0", d); else passed++;
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    cycle(0, 1, 1, 32'h4, 4'hE);
    for (int k = 1; k <= 5; k++) cycle(0, 0, 0, 0, 4'hA);
    rd(0, d); total++; if (d !== 32'hE) $display("FAIL pre_collision_data got %h want %h", d, 32'hE); else passed++;
    cycle(0, 1, 2, 32'h4, 4'hA);
    rd(2, d); total++; if (d !== 32'h4) $display("FAIL collision_edge got %h want 4", d); else passed++;
    rd(0, d); total++; if (d !== 32'hA) $display("FAIL collision_data got %h want %h", d, 32'hA); else passed++;
    total++; if (irq !== 1'b1) $display("FAIL collision_irq got %b want 1", irq); else passed++;
    cycle(0, 1, 2, 32'h4, 4'hA);
    rd(2, d); total++; if (d !== 32'h0) $display("FAIL late_w1c_edge got %h want 0", d); else passed++;
    total++; if (irq !== 1'b0) $display("FAIL late_w1c_irq got %b want 0", irq); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    for (int k = 1; k <= 4; k++) cycle(0, 0, 0, 0, 4'h2);
    rd(0, d); total++; if (d !== 32'hA) $display("FAIL mid_count_data got %h want %h", d, 32'hA); else passed++;
    cycle(1, 0, 0, 0, 4'h2);
    rd(0, d); total++; if (d !== 32'hF) $display("FAIL mid_reset_data got %h want %h", d, 32'hF); else passed++;
    rd(2, d); total++; if (d !== 32'h0) $display("FAIL mid_reset_edge got %h want 0", d); else passed++;
    for (int k = 1; k <= 6; k++) begin
      cycle(0, 0, 0, 0, 4'h2);
      rd(0, d);
      total++;
      if (d !== ((k < 6) ? 32'hF : 32'h2)) $display("FAIL post_reset_latency cyc%0d got %h want %h", k, d, (k < 6) ? 32'hF : 32'h2);
      else passed++;
    end
    rd(2, d); total++; if (d !== 32'hD) $display("FAIL post_reset_edge got %h want %h", d, 32'hD); else passed++;
  endtask

  task automatic test_random();
    logic [31:0]  d;
    logic [W-1:0] pins;
    int           hold;
    pins = 4'hF;
    hold = 0;
    cycle(1, 0, 0, 0, pins);
    for (int k = 0; k < 1500; k++) begin
      if (hold == 0) begin
        pins = W'($urandom);
        hold = $urandom_range(1, 8);
      end
      hold--;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
            2'($urandom), $urandom, pins);
      total++; if (irq !== |(m_edge & m_mask)) $display("FAIL rand_irq cyc%0d got %b want %b", k, irq, |(m_edge & m_mask)); else passed++;
      rd(0, d); total++; if (d !== 32'(m_stable)) $display("FAIL rand_data cyc%0d got %h want %h", k, d, 32'(m_stable)); else passed++;
      rd(1, d); total++; if (d !== 32'(m_mask)) $display("FAIL rand_mask cyc%0d got %h want %h", k, d, 32'(m_mask)); else passed++;
      rd(2, d); total++; if (d !== 32'(m_edge)) $display("FAIL rand_edge cyc%0d got %h want %h", k, d, 32'(m_edge)); else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 6; i++) hist[i] = '1;
    e          = 6;
    m_stable   = '1;
    m_edge     = '0;
    m_mask     = '0;
    reset      = 1'b1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = '0;
    in_port    = '1;
    test_reset();
    test_debounce();
    test_glitch();
    test_mask_irq();
    test_w1c_collision();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
